// File: rtl/status_reg_reader.sv
// IPbus read-side slave for the status register set, with a freeze snapshot
// and an LSB/MSB shadow latch so the split trigger timestamp reads atomically.
//
// state    | meaning
// IDLE     | waiting for ipb_strobe; captures offset, direction and write data
// DECODE   | builds the response and applies control/pair side effects
// RESP     | ipb_ack or ipb_err high for this single cycle
// WAIT_LOW | holds off until the master drops ipb_strobe
module status_reg_reader #(
   parameter int          NREG      = 34,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          LSB_IDX   = 12,
   parameter int          MSB_IDX   = 13
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [32*NREG-1:0]   status_flat,
   input  logic                 ipb_strobe,
   input  logic                 ipb_write,
   input  logic [31:0]          ipb_addr,
   input  logic [31:0]          ipb_wdata,
   output logic [31:0]          ipb_rdata,
   output logic                 ipb_ack,
   output logic                 ipb_err,
   output logic                 frozen
);

   localparam int            IW    = $clog2(NREG);
   localparam logic [IW-1:0] LSB_I = IW'(LSB_IDX);
   localparam logic [IW-1:0] MSB_I = IW'(MSB_IDX);

   typedef enum logic [1:0] {IDLE, DECODE, RESP, WAIT_LOW} state_t;

   state_t      state_q, state_d;
   logic [31:0] off_q, off_d;
   logic        write_q, write_d;
   logic [1:0]  wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic        frozen_q, frozen_d;
   logic        pair_valid_q, pair_valid_d;
   logic [31:0] shadow_q, shadow_d;
   logic [31:0] snapshot_q [NREG];
   logic [31:0] snapshot_d [NREG];

   logic [31:0] live [NREG];
   logic [IW-1:0] idx;
   logic          is_reg, is_ctrl, ok;
   logic [31:0]   src_sel, src_msb, rd;

   always_comb begin
      for (int i = 0; i < NREG; i++) live[i] = status_flat[32*i +: 32];
   end

   assign idx     = off_q[IW-1:0];
   assign is_reg  = off_q < 32'(NREG);
   assign is_ctrl = off_q == 32'(NREG);
   assign src_sel = frozen_q ? snapshot_q[idx] : live[idx];
   assign src_msb = frozen_q ? snapshot_q[MSB_IDX] : live[MSB_IDX];

   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      ack_d        = 1'b0;
      err_d        = 1'b0;
      frozen_d     = frozen_q;
      pair_valid_d = pair_valid_q;
      shadow_d     = shadow_q;
      snapshot_d   = snapshot_q;
      ok           = 1'b0;
      rd           = 32'd0;
      case (state_q)
         IDLE: begin
            if (ipb_strobe) begin
               off_d   = ipb_addr - BASE_ADDR;
               write_d = ipb_write;
               wdata_d = ipb_wdata[1:0];
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (is_reg && !write_q) begin
               ok = 1'b1;
               if (idx == MSB_I && pair_valid_q) begin
                  rd           = shadow_q;
                  pair_valid_d = 1'b0;
               end else begin
                  rd = src_sel;
               end
               if (idx == LSB_I) begin
                  shadow_d     = src_msb;
                  pair_valid_d = 1'b1;
               end
            end else if (is_ctrl) begin
               ok = 1'b1;
               if (write_q) begin
                  // Freezing an already frozen view keeps the original snapshot.
                  if (wdata_q[0]) begin
                     if (!frozen_q) begin
                        snapshot_d = live;
                        frozen_d   = 1'b1;
                     end
                  end else begin
                     frozen_d = 1'b0;
                  end
                  if (wdata_q[1]) pair_valid_d = 1'b0;
               end else begin
                  rd = {30'd0, pair_valid_q, frozen_q};
               end
            end
            ack_d   = ok;
            err_d   = !ok;
            rdata_d = ok ? rd : 32'd0;
            state_d = RESP;
         end
         RESP: begin
            state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!ipb_strobe) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         off_q        <= 32'd0;
         write_q      <= 1'b0;
         wdata_q      <= 2'd0;
         rdata_q      <= 32'd0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
         frozen_q     <= 1'b0;
         pair_valid_q <= 1'b0;
         shadow_q     <= 32'd0;
         for (int i = 0; i < NREG; i++) snapshot_q[i] <= 32'd0;
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         frozen_q     <= frozen_d;
         pair_valid_q <= pair_valid_d;
         shadow_q     <= shadow_d;
         snapshot_q   <= snapshot_d;
      end
   end

   assign ipb_rdata = rdata_q;
   assign ipb_ack   = ack_q;
   assign ipb_err   = err_q;
   assign frozen    = frozen_q;

endmodule

// File: tb/tb_status_reg_reader.sv
// Bench for status_reg_reader: directed scenarios followed by random traffic,
// all checked against a rule-level model of the register view.
module tb_status_reg_reader;

   localparam int          NREG = 34;
   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam int          LSB  = 12;
   localparam int          MSB  = 13;

   logic                clk = 1'b0;
   logic                reset;
   logic [32*NREG-1:0]  status_flat;
   logic                ipb_strobe, ipb_write;
   logic [31:0]         ipb_addr, ipb_wdata, ipb_rdata;
   logic                ipb_ack, ipb_err, frozen;

   int checks = 0;
   int errors = 0;

   logic [31:0] live_m [NREG];
   logic [31:0] snap_m [NREG];
   logic        frz_m, pv_m;
   logic [31:0] shadow_m;

   status_reg_reader #(.NREG(NREG), .BASE_ADDR(BASE), .LSB_IDX(LSB), .MSB_IDX(MSB)) dut (
      .clk(clk), .reset(reset), .status_flat(status_flat),
      .ipb_strobe(ipb_strobe), .ipb_write(ipb_write), .ipb_addr(ipb_addr),
      .ipb_wdata(ipb_wdata), .ipb_rdata(ipb_rdata), .ipb_ack(ipb_ack),
      .ipb_err(ipb_err), .frozen(frozen)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_live();
      for (int i = 0; i < NREG; i++) status_flat[32*i +: 32] = live_m[i];
   endtask

   task automatic model_reset();
      frz_m = 1'b0; pv_m = 1'b0; shadow_m = 32'd0;
      for (int i = 0; i < NREG; i++) snap_m[i] = 32'd0;
   endtask

   function automatic logic [31:0] view(input int i);
      return frz_m ? snap_m[i] : live_m[i];
   endfunction

   // Expected response of one transaction, applying its side effects to the model.
   task automatic model_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            output logic ak, output logic [31:0] rd);
      logic [31:0] off;
      int i;
      off = addr - BASE;
      ak = 1'b0; rd = 32'd0;
      if (off < NREG && !wr) begin
         i = int'(off);
         ak = 1'b1;
         if (i == MSB && pv_m) begin rd = shadow_m; pv_m = 1'b0; end
         else rd = view(i);
         if (i == LSB) begin shadow_m = view(MSB); pv_m = 1'b1; end
      end else if (off == NREG) begin
         ak = 1'b1;
         if (wr) begin
            if (wd[0] && !frz_m) begin snap_m = live_m; frz_m = 1'b1; end
            if (!wd[0]) frz_m = 1'b0;
            if (wd[1]) pv_m = 1'b0;
         end else begin
            rd = {30'd0, pv_m, frz_m};
         end
      end
   endtask

   task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic ak, output logic er, output int lat);
      @(negedge clk);
      ipb_strobe = 1'b1; ipb_write = wr; ipb_addr = addr; ipb_wdata = wd;
      lat = -1; ak = 1'b0; er = 1'b0; rd = 32'd0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (ipb_ack || ipb_err) begin
            lat = c; ak = ipb_ack; er = ipb_err; rd = ipb_rdata;
            break;
         end
      end
      ipb_strobe = 1'b0; ipb_write = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd);
      logic        eak, ak, er;
      logic [31:0] erd;
      int          lat;
      model_txn(wr, addr, wd, eak, erd);
      bus(wr, addr, wd, rd, ak, er, lat);
      check({tag, " latency"}, 32'(lat), 32'd2);
      check({tag, " ack"}, {31'd0, ak}, {31'd0, eak});
      check({tag, " err"}, {31'd0, er}, {31'd0, !eak});
      if (!wr || !eak) check({tag, " rdata"}, rd, erd);
      check({tag, " frozen"}, {31'd0, frozen}, {31'd0, frz_m});
   endtask

   initial begin
      logic [31:0] rd, old5, erd;
      logic        eak;
      int          n_ack, n_err, lat;

      reset = 1'b1; ipb_strobe = 1'b0; ipb_write = 1'b0; ipb_addr = 32'd0; ipb_wdata = 32'd0;
      for (int i = 0; i < NREG; i++) live_m[i] = $urandom;
      live_m[0] = 32'hA1B2_0305;
      push_live();
      model_reset();
      repeat (3) @(negedge clk);
      check("reset rdata", ipb_rdata, 32'd0);
      check("reset ack", {31'd0, ipb_ack}, 32'd0);
      check("reset err", {31'd0, ipb_err}, 32'd0);
      check("reset frozen", {31'd0, frozen}, 32'd0);
      reset = 1'b0;

      txn("rd0", 1'b0, BASE, 32'd0, rd);
      check("rd0 value", rd, 32'hA1B2_0305);

      live_m[12] = 32'h1111_2222; live_m[13] = 32'h0000_0ABC; push_live();
      txn("rd12", 1'b0, BASE + 12, 32'd0, rd);
      check("rd12 value", rd, 32'h1111_2222);
      live_m[13] = 32'h0000_0ABD; push_live();
      txn("rd13 shadow", 1'b0, BASE + 13, 32'd0, rd);
      check("rd13 shadow value", rd, 32'h0000_0ABC);
      txn("rd13 live", 1'b0, BASE + 13, 32'd0, rd);
      check("rd13 live value", rd, 32'h0000_0ABD);

      txn("freeze", 1'b1, BASE + NREG, 32'd1, rd);
      old5 = live_m[5];
      for (int i = 0; i < NREG; i++) live_m[i] = ~live_m[i] ^ $urandom;
      push_live();
      txn("rd5 frozen", 1'b0, BASE + 5, 32'd0, rd);
      check("rd5 frozen value", rd, old5);
      txn("rd ctrl", 1'b0, BASE + NREG, 32'd0, rd);
      check("rd ctrl value", rd, 32'h1);
      txn("unfreeze", 1'b1, BASE + NREG, 32'd0, rd);
      txn("rd5 live", 1'b0, BASE + 5, 32'd0, rd);
      check("rd5 live value", rd, live_m[5]);

      txn("rd35", 1'b0, BASE + NREG + 1, 32'd0, rd);
      txn("wr3", 1'b1, BASE + 3, 32'hDEAD_BEEF, rd);
      txn("below base", 1'b0, 32'h0000_00FF, 32'd0, rd);

      txn("freeze2", 1'b1, BASE + NREG, 32'd1, rd);
      @(negedge clk);
      ipb_strobe = 1'b1; ipb_write = 1'b0; ipb_addr = BASE + 2;
      @(negedge clk);
      reset = 1'b1; ipb_strobe = 1'b0;
      n_ack = 0; n_err = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         reset = 1'b0;
         n_ack += int'(ipb_ack); n_err += int'(ipb_err);
      end
      model_reset();
      check("abort ack count", 32'(n_ack), 32'd0);
      check("abort err count", 32'(n_err), 32'd0);
      check("abort frozen", {31'd0, frozen}, 32'd0);
      txn("after abort", 1'b0, BASE + 2, 32'd0, rd);

      model_txn(1'b0, BASE + 1, 32'd0, eak, erd);
      @(negedge clk);
      ipb_strobe = 1'b1; ipb_write = 1'b0; ipb_addr = BASE + 1;
      n_ack = 0; n_err = 0; lat = -1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (ipb_ack && lat < 0) begin lat = c; rd = ipb_rdata; end
         n_ack += int'(ipb_ack); n_err += int'(ipb_err);
      end
      check("hold latency", 32'(lat), 32'd2);
      check("hold ack count", 32'(n_ack), 32'd1);
      check("hold err count", 32'(n_err), 32'd0);
      check("hold rdata", rd, erd);
      ipb_strobe = 1'b0;
      @(negedge clk);
      ipb_strobe = 1'b1;
      model_txn(1'b0, BASE + 1, 32'd0, eak, erd);
      lat = -1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (ipb_ack) begin lat = c; rd = ipb_rdata; break; end
      end
      ipb_strobe = 1'b0;
      check("rearm latency", 32'(lat), 32'd2);
      check("rearm rdata", rd, erd);
      repeat (2) @(negedge clk);

      for (int k = 0; k < 80; k++) begin
         int          op;
         logic [31:0] a;
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < NREG; i++) live_m[i] = $urandom;
            push_live();
         end
         op = int'($urandom_range(0, 9));
         case (op)
            0, 1:    txn("rand pair lsb", 1'b0, BASE + LSB, 32'd0, rd);
            2, 3:    txn("rand pair msb", 1'b0, BASE + MSB, 32'd0, rd);
            4:       txn("rand ctrl wr", 1'b1, BASE + NREG, 32'($urandom_range(0, 3)), rd);
            5:       txn("rand ctrl rd", 1'b0, BASE + NREG, 32'd0, rd);
            6:       txn("rand stat wr", 1'b1, BASE + 32'($urandom_range(0, NREG - 1)), $urandom, rd);
            7: begin
               a = $urandom;
               txn("rand wild", $urandom_range(0, 1) == 1, a, $urandom, rd);
            end
            default: txn("rand rd", 1'b0, BASE + 32'($urandom_range(0, NREG + 2)), 32'd0, rd);
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/status_reg_reader.md
Name: status_reg_reader

Overview:
- IPbus slave that serves the Rider status register set (board status, errors, FSM state, trigger counts, XADC readings, DDR3 burst counts) to the IPbus fabric, as the read side of the status register block's outputs.
- Provides registered read responses with ack/err signalling.
- Provides a freeze-snapshot control so software can read all registers coherently.
- Provides a hardware LSB/MSB pair latch so the 44-bit trigger timestamp reads atomically.

Parameters:
- NREG, 34, number of 32-bit status registers on status_flat.
- BASE_ADDR, 32'h0000_0000, IPbus base address of register 0.
- LSB_IDX, 12, register index whose read latches its partner.
- MSB_IDX, 13, partner register index returned from the shadow.

Ports:
- clk  in  1  user interface clock.
- reset  in  1  synchronous, active-high reset.
- status_flat  in  32*NREG  live status registers; register i at bits [32*i+31:32*i].
- ipb_strobe  in  1  transaction request; held high until ipb_ack or ipb_err.
- ipb_write  in  1  1 = write, 0 = read; valid while ipb_strobe is high.
- ipb_addr  in  32  byte-agnostic word address.
- ipb_wdata  in  32  write data.
- ipb_rdata  out  32  read data; valid in the ack cycle.
- ipb_ack  out  1  one-cycle success pulse.
- ipb_err  out  1  one-cycle error pulse.
- frozen  out  1  snapshot active (diagnostic).

Behaviour:
- Reset: ipb_rdata=0, ipb_ack=0, ipb_err=0, frozen=0, pair_valid=0, shadow=0, snapshot=0; FSM enters IDLE. Reset during a transaction aborts it; no ack or err is issued for it.
- Address decode: off = ipb_addr - BASE_ADDR (32-bit unsigned wrap).
  - off < NREG: status register.
  - off == NREG: control register CTRL.
  - Anything else, including addresses below BASE_ADDR (wrap to large values): error.
- Source word: src(i) = frozen ? snapshot[i] : status_flat[i].
- FSM states IDLE, DECODE, RESP, WAIT_LOW:
  - IDLE: ipb_strobe=1 -> register off and ipb_write -> DECODE.
  - DECODE: compute response; register rdata and the ack/err flag -> RESP.
  - RESP: assert exactly one of ipb_ack / ipb_err for one cycle -> WAIT_LOW.
  - WAIT_LOW: stay until ipb_strobe=0 -> IDLE.
  - Strobe-rise to ack/err latency: exactly 2 cycles. Back-to-back transactions require at least one strobe-low cycle. Strobe dropping early in DECODE does not cancel the response.
- Reads of status register i:
  - i == MSB_IDX and pair_valid=1: rdata = shadow; pair_valid cleared.
  - otherwise: rdata = src(i).
  - i == LSB_IDX: additionally shadow <= src(MSB_IDX) and pair_valid <= 1, in the same cycle as rdata capture. A repeated LSB read re-latches the shadow.
  - Reads of other indices leave pair_valid unchanged.
- Writes to status registers: ipb_err; no state change.
- CTRL read: rdata = {30'd0, pair_valid, frozen}.
- CTRL write, acked:
  - wdata[0]=1 with frozen=0: snapshot[all] <= status_flat in the DECODE cycle; frozen <= 1.
  - wdata[0]=1 with frozen=1: no re-capture.
  - wdata[0]=0: frozen <= 0.
  - wdata[1]=1: pair_valid <= 0 (write-1-to-clear).
- ipb_rdata is held at its last value outside the ack cycle. ipb_rdata = 0 on err.

Test Plan:
- Reset, then read off 0 with status_flat reg0=32'hA1B2_0305 -> ipb_ack 2 cycles after strobe rise, rdata=32'hA1B2_0305, ipb_err=0.
- Read off 12 (live 32'h1111_2222, reg13=32'h0000_0ABC); change reg13 to 32'h0000_0ABD; read off 13 -> rdata=32'h0000_0ABC. Read off 13 again -> 32'h0000_0ABD.
- Write CTRL=1; change all status inputs; read off 5 -> returns pre-write value. Read CTRL -> 32'h1. Write CTRL=0, read off 5 -> returns the new value.
- Read off NREG+1 (35) -> ipb_err pulse, ipb_ack=0, rdata=0. Write off 3 -> ipb_err. Read with addr below BASE_ADDR (BASE_ADDR=32'h100, addr 32'hFF) -> ipb_err.
- Assert reset in the DECODE cycle of a read -> no ack/err pulse, frozen=0; next read completes normally with 2-cycle latency.
- Hold ipb_strobe high for 10 cycles after ack -> exactly one ack pulse. Deassert one cycle, reassert -> second ack 2 cycles later.
